// File: rtl/llr_frame_feeder.sv
// Scales/saturates a raw LLR sample stream, assembles N_V-sample frames in a
// ping-pong buffer and replays each frame to the decoder as N_LLRS-wide chunks.
module llr_frame_feeder #(
    parameter int unsigned WIDTH_RAW = 8,
    parameter int unsigned WIDTH_IN  = 6,
    parameter int unsigned FRAC_DROP = 2,
    parameter int unsigned N_LLRS    = 4,
    parameter int unsigned N_V       = 31
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WIDTH_RAW-1:0]   s_llr,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          dec_busy,
    output logic [N_LLRS*WIDTH_IN-1:0]    databus_in,
    output logic                          first_data,
    output logic                          data_valid,
    output logic                          frame_err
);

    localparam int unsigned L_SEG     = (N_V - 1) / N_LLRS;
    localparam int unsigned FIRST_CNT = (N_V - 1) % N_LLRS + 1;
    localparam int unsigned CNT_W     = (N_V > 1) ? $clog2(N_V) : 1;
    localparam int unsigned CH_W      = $clog2(L_SEG + 2);
    localparam int unsigned BUS_W     = N_LLRS * WIDTH_IN;

    localparam logic signed [WIDTH_RAW-1:0] SAT_POS = WIDTH_RAW'((2 ** (WIDTH_IN - 1)) - 1);
    localparam logic signed [WIDTH_RAW-1:0] SAT_NEG = -SAT_POS;

    typedef enum logic [1:0] {FILL, DRAIN_ERR, STALL} fill_st_t;
    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY} send_st_t;

    logic [WIDTH_IN-1:0] mem_q [2][N_V];
    logic [1:0]          full_q;
    logic                fill_bank_q;
    logic                send_bank_q;
    logic [CNT_W-1:0]    fill_cnt_q;
    logic [CH_W-1:0]     chunk_q;
    fill_st_t            fill_st_q;
    send_st_t            send_st_q;
    logic                s_ready_q;
    logic                first_data_q;
    logic                data_valid_q;
    logic                frame_err_q;
    logic [BUS_W-1:0]    databus_q;

    logic signed [WIDTH_RAW-1:0] shifted_c;
    logic [WIDTH_IN-1:0]         llr_sat_c;
    logic                        accept_c;
    logic                        write_c;
    logic                        last_chunk_c;
    logic                        cur_free_c;
    logic                        other_free_c;
    logic [CH_W-1:0]             chunk_sel_c;
    logic [BUS_W-1:0]            chunk_c;

    // Floor shift then symmetric saturation; the most negative code never appears.
    always_comb begin
        shifted_c = s_llr >>> FRAC_DROP;
        if (shifted_c > SAT_POS) begin
            llr_sat_c = WIDTH_IN'(SAT_POS);
        end else if (shifted_c < SAT_NEG) begin
            llr_sat_c = WIDTH_IN'(SAT_NEG);
        end else begin
            llr_sat_c = WIDTH_IN'(shifted_c);
        end
    end

    assign accept_c     = s_valid && s_ready_q;
    assign write_c      = accept_c && (fill_st_q == FILL);
    assign last_chunk_c = (send_st_q != S_IDLE) && (chunk_q == CH_W'(L_SEG));

    // A bank freed by the sender this cycle counts as free for the fill side.
    assign cur_free_c   = !full_q[fill_bank_q]
                          || (last_chunk_c && (send_bank_q == fill_bank_q));
    assign other_free_c = !full_q[~fill_bank_q]
                          || (last_chunk_c && (send_bank_q == ~fill_bank_q));

    // Chunk k slot j holds sample FIRST_CNT-1+k*N_LLRS-j; chunk 0 only fills FIRST_CNT slots.
    always_comb begin
        int top_idx;
        int idx;
        chunk_sel_c = (send_st_q == S_IDLE) ? '0 : chunk_q + CH_W'(1);
        chunk_c     = '0;
        top_idx     = int'(FIRST_CNT) - 1 + int'(chunk_sel_c) * int'(N_LLRS);
        for (int j = 0; j < int'(N_LLRS); j++) begin
            idx = top_idx - j;
            if ((chunk_sel_c != '0 || j < int'(FIRST_CNT)) && idx >= 0 && idx < int'(N_V)) begin
                chunk_c[j*WIDTH_IN +: WIDTH_IN] = mem_q[send_bank_q][CNT_W'(idx)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_c) begin
            mem_q[fill_bank_q][fill_cnt_q] <= llr_sat_c;
        end
    end

    // Fill-side and send-side state machines; they share the bank-full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_st_q    <= FILL;
            send_st_q    <= S_IDLE;
            full_q       <= '0;
            fill_bank_q  <= 1'b0;
            send_bank_q  <= 1'b0;
            fill_cnt_q   <= '0;
            chunk_q      <= '0;
            s_ready_q    <= 1'b1;
            first_data_q <= 1'b0;
            data_valid_q <= 1'b0;
            databus_q    <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            case (fill_st_q)
                FILL: begin
                    if (accept_c) begin
                        if (fill_cnt_q == CNT_W'(N_V - 1)) begin
                            fill_cnt_q <= '0;
                            if (s_last) begin
                                full_q[fill_bank_q] <= 1'b1;
                                fill_bank_q         <= ~fill_bank_q;
                                if (!other_free_c) begin
                                    fill_st_q <= STALL;
                                    s_ready_q <= 1'b0;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                                fill_st_q   <= DRAIN_ERR;
                            end
                        end else if (s_last) begin
                            frame_err_q <= 1'b1;
                            fill_cnt_q  <= '0;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN_ERR: begin
                    if (accept_c && s_last) begin
                        fill_st_q <= FILL;
                    end
                end
                STALL: begin
                    if (cur_free_c) begin
                        fill_st_q <= FILL;
                        s_ready_q <= 1'b1;
                    end
                end
                default: fill_st_q <= FILL;
            endcase

            case (send_st_q)
                S_IDLE: begin
                    if (full_q[send_bank_q] && !dec_busy) begin
                        databus_q    <= chunk_c;
                        first_data_q <= 1'b1;
                        data_valid_q <= 1'b1;
                        chunk_q      <= '0;
                        send_st_q    <= S_FIRST;
                    end
                end
                S_FIRST, S_BODY: begin
                    first_data_q <= 1'b0;
                    if (last_chunk_c) begin
                        data_valid_q        <= 1'b0;
                        databus_q           <= '0;
                        full_q[send_bank_q] <= 1'b0;
                        send_bank_q         <= ~send_bank_q;
                        send_st_q           <= S_IDLE;
                    end else begin
                        databus_q    <= chunk_c;
                        data_valid_q <= 1'b1;
                        chunk_q      <= chunk_q + CH_W'(1);
                        send_st_q    <= S_BODY;
                    end
                end
                default: send_st_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign databus_in = databus_q;
    assign first_data = first_data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_llr_frame_feeder.sv
// Bench for llr_frame_feeder: frame-level reference model feeds a scoreboard
// that a decoder-view monitor drains.
module tb_llr_frame_feeder;

    localparam int W    = 6;
    localparam int NL   = 4;
    localparam int NV   = 31;
    localparam int LSEG = (NV - 1) / NL;
    localparam int FW   = NV * W;
    localparam int AW   = (LSEG + 1) * NL * W;
    localparam int SATV = 31;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] s_llr = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              dec_busy = 1'b0;
    logic              s_ready;
    logic [NL*W-1:0]   databus_in;
    logic              first_data;
    logic              data_valid;
    logic              frame_err;

    llr_frame_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .s_llr      (s_llr),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .dec_busy   (dec_busy),
        .databus_in (databus_in),
        .first_data (first_data),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_exp = 0;
    int err_seen = 0;
    int chunk_n = -1;
    int first_cyc = 0;
    int last_acc_cyc = 0;
    bit rand_busy = 1'b0;
    bit drv_done = 1'b0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] exp_frame;
    logic [AW-1:0] acc;

    // Reference model state: where the current frame stands, and whether we are discarding.
    int            m_idx = 0;
    bit            m_drop = 1'b0;
    logic [FW-1:0] m_cur = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rand_busy) dec_busy = 1'($urandom_range(0, 1));

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Floor divide by 4, then clamp symmetrically to +/-31.
    function automatic int conv(input int raw);
        int v;
        v = (raw >= 0) ? raw / 4 : -((-raw + 3) / 4);
        if (v > SATV) v = SATV;
        if (v < -SATV) v = -SATV;
        return v;
    endfunction

    task automatic model_accept(input int raw, input bit last);
        if (m_drop) begin
            if (last) begin
                m_drop = 1'b0;
                m_idx  = 0;
            end
        end else begin
            m_cur[(NV-1-m_idx)*W +: W] = W'(conv(raw));
            if (m_idx == NV - 1) begin
                if (last) exp_q.push_back(m_cur);
                else begin
                    err_exp++;
                    m_drop = 1'b1;
                end
                m_idx = 0;
            end else if (last) begin
                err_exp++;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_sample(input int raw, input bit last);
        bit done = 1'b0;
        s_llr   = 8'(raw);
        s_last  = last;
        s_valid = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (s_ready) done = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (done) begin
            model_accept(raw, last);
            last_acc_cyc = cyc;
        end else begin
            check(1'b0, "accept_timeout", 0, 1);
        end
    endtask

    // mode 0: ramp 4*i, mode 1: random, mode 2: saturation corners then random.
    task automatic send_frame(input int n, input int last_at, input int mode, input bit gaps);
        int sat_vals[5] = '{127, -128, -125, -124, 5};
        int raw;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) raw = 4 * i;
            else if (mode == 2 && i < 5) raw = sat_vals[i];
            else raw = int'($urandom_range(0, 255)) - 128;
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            push_sample(raw, i == last_at);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 1500 && !ok; k++) begin
            if (exp_q.size() == 0 && chunk_n < 0 && !data_valid) ok = 1'b1;
            else @(negedge clk);
        end
        check(ok, "drain_timeout", exp_q.size(), 0);
    endtask

    // Decoder-view monitor: shift chunks in from the LSB end, compare whole frames.
    always @(negedge clk) begin
        if (rst) begin
            chunk_n = -1;
        end else begin
            if (frame_err) err_seen++;
            if (data_valid) begin
                if (chunk_n < 0) begin
                    check(first_data == 1'b1, "first_data_set", longint'(first_data), 1);
                    chunk_n   = 0;
                    acc       = '0;
                    first_cyc = cyc;
                end else begin
                    check(first_data == 1'b0, "first_data_clr", longint'(first_data), 0);
                end
                acc = {acc[AW-NL*W-1:0], databus_in};
                chunk_n++;
                if (chunk_n == LSEG + 1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected actual=%h required=none", acc);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        if (acc != {{(AW-FW){1'b0}}, exp_frame}) begin
                            errors++;
                            $display("FAIL frame_data actual=%h required=%h", acc,
                                     {{(AW-FW){1'b0}}, exp_frame});
                        end
                    end
                    chunk_n = -1;
                end
            end else begin
                check(databus_in == '0 && first_data == 1'b0, "idle_bus",
                      longint'(databus_in), 0);
                check(chunk_n < 0, "burst_gap", chunk_n, -1);
                chunk_n = -1;
            end
        end
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check(s_ready == 1'b1, "rst_s_ready", longint'(s_ready), 1);
        check(data_valid == 1'b0, "rst_data_valid", longint'(data_valid), 0);
        check(first_data == 1'b0, "rst_first_data", longint'(first_data), 0);
        check(databus_in == '0, "rst_databus", longint'(databus_in), 0);
        check(frame_err == 1'b0, "rst_frame_err", longint'(frame_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // In-order ramp frame, decoder idle; also latency last-accept -> chunk 0.
        send_frame(NV, NV - 1, 0, 1'b0);
        wait_idle();
        check(first_cyc - last_acc_cyc == 1, "latency", first_cyc - last_acc_cyc, 1);

        send_frame(NV, NV - 1, 2, 1'b0);
        wait_idle();

        // Three frames against a busy decoder: fill stalls after two.
        dec_busy = 1'b1;
        drv_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(NV, NV - 1, 1, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        repeat (2 * NV + 10) @(negedge clk);
        check(s_ready == 1'b0, "stall_ready", longint'(s_ready), 0);
        check(exp_q.size() == 2, "stall_queued", exp_q.size(), 2);
        dec_busy = 1'b0;
        for (int k = 0; k < 600 && !drv_done; k++) @(negedge clk);
        check(drv_done, "busy_driver_done", drv_done, 1);
        wait_idle();

        // Early last, then a good frame.
        send_frame(11, 10, 1, 1'b0);
        send_frame(NV, NV - 1, 1, 1'b0);
        wait_idle();

        // Missing last, five trailing samples dropped, then a good frame.
        send_frame(NV, -1, 1, 1'b0);
        send_frame(5, 4, 1, 1'b0);
        send_frame(NV, NV - 1, 1, 1'b1);
        wait_idle();

        // Random frames with input gaps and a randomly busy decoder.
        rand_busy = 1'b1;
        for (int f = 0; f < 6; f++) send_frame(NV, NV - 1, 1, 1'b1);
        rand_busy = 1'b0;
        dec_busy  = 1'b0;
        wait_idle();

        // Reset while chunk 3 is on the bus.
        send_frame(NV, NV - 1, 1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (data_valid && first_data) seen = 1'b1;
            else @(negedge clk);
        end
        check(seen, "reset_wait_first", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_idx  = 0;
        m_drop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(data_valid == 1'b0, "post_rst_valid", longint'(data_valid), 0);
        check(s_ready == 1'b1, "post_rst_ready", longint'(s_ready), 1);
        @(negedge clk);
        send_frame(NV, NV - 1, 1, 1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        check(err_seen == err_exp, "frame_err_count", err_seen, err_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
